// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - issues a stored program of ALU ops to the accumulator and streams back {of, r}
module accum_sequencer #(
  parameter int WIDTH = 4,
  parameter int MODEW = 4,
  parameter int AW    = 4,
  parameter int LAT   = 1
) (
  input  logic                       Clk,
  input  logic                       nReset,
  input  logic                       prog_we,
  input  logic [AW-1:0]              prog_addr,
  input  logic [2*WIDTH+MODEW:0]     prog_data,
  input  logic                       start,
  input  logic [AW:0]                count,
  output logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           b,
  output logic [MODEW-1:0]           m,
  output logic                       cin,
  input  logic [WIDTH-1:0]           r,
  input  logic                       of,
  output logic                       busy,
  output logic                       res_valid,
  output logic [WIDTH:0]             res_data,
  output logic [AW-1:0]              res_idx,
  output logic [AW:0]                of_count,
  output logic                       done
);

  localparam int PW = 2*WIDTH + MODEW + 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [AW:0] DEPTH_N = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_FIN} state_t;

  state_t          state;
  logic [PW-1:0]   ram [1 << AW];
  logic [AW:0]     n;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   wcnt;
  logic [AW:0]     count_min;

  assign count_min = (count > DEPTH_N) ? DEPTH_N : count;

  // Program contents are not reset; writes are locked out for the whole run.
  always_ff @(posedge Clk) begin
    if (prog_we && !busy)
      ram[prog_addr] <= prog_data;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      n         <= '0;
      idx       <= '0;
      wcnt      <= '0;
      a         <= '0;
      b         <= '0;
      m         <= '0;
      cin       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      of_count  <= '0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n        <= count_min;
            of_count <= '0;
            idx      <= '0;
            if (count_min == '0) begin
              state <= S_FIN;
            end else begin
              state <= S_ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          {a, b, m, cin} <= ram[idx];
          wcnt           <= '0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == CW'(LAT - 1))
            state <= S_CAPTURE;
          else
            wcnt <= wcnt + CW'(1);
        end
        S_CAPTURE: begin
          res_data  <= {of, r};
          res_idx   <= idx;
          res_valid <= 1'b1;
          if (of && (of_count != '1))
            of_count <= of_count + (AW+1)'(1);
          if (({1'b0, idx} + (AW+1)'(1)) == n) begin
            state <= S_FIN;
          end else begin
            idx   <= idx + AW'(1);
            state <= S_ISSUE;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// tb/tb_accum_sequencer.sv - directed bench for accum_sequencer with a 1-cycle add/sub/and accumulator model
module tb_accum_sequencer;

  localparam int WIDTH = 4;
  localparam int MODEW = 4;
  localparam int AW    = 4;
  localparam int LAT   = 1;

  logic                   Clk = 1'b0;
  logic                   nReset = 1'b0;
  logic                   prog_we = 1'b0;
  logic [AW-1:0]          prog_addr = '0;
  logic [2*WIDTH+MODEW:0] prog_data = '0;
  logic                   start = 1'b0;
  logic [AW:0]            count = '0;
  logic [WIDTH-1:0]       a, b, r;
  logic [MODEW-1:0]       m;
  logic                   cin, of;
  logic                   busy, res_valid, done;
  logic [WIDTH:0]         res_data;
  logic [AW-1:0]          res_idx;
  logic [AW:0]            of_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc;
  int done_cnt;
  int done_cyc;
  int q_idx[$];
  int q_data[$];
  int q_cyc[$];

  accum_sequencer #(.WIDTH(WIDTH), .MODEW(MODEW), .AW(AW), .LAT(LAT)) dut (
    .Clk(Clk), .nReset(nReset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .count(count),
    .a(a), .b(b), .m(m), .cin(cin), .r(r), .of(of),
    .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .of_count(of_count), .done(done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Accumulator: result valid one edge after operands (m=0 add, m=1 sub with borrow in of, m=3 and).
  always @(posedge Clk) begin
    if (m == 4'd0)      {of, r} <= {1'b0, a} + {1'b0, b} + {4'b0, cin};
    else if (m == 4'd1) {of, r} <= {1'b0, a} - {1'b0, b} - {4'b0, cin};
    else if (m == 4'd3) {of, r} <= {1'b0, a & b};
    else                {of, r} <= '0;
  end

  always @(negedge Clk) begin
    if (nReset) begin
      if (res_valid) begin
        q_idx.push_back(int'(res_idx));
        q_data.push_back(int'(res_data));
        q_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic prog_write(input int addr, input logic [3:0] av, input logic [3:0] bv,
                            input logic [3:0] mv, input logic cv);
    @(negedge Clk);
    prog_we = 1'b1; prog_addr = AW'(addr); prog_data = {av, bv, mv, cv};
    @(negedge Clk);
    prog_we = 1'b0;
  endtask

  task automatic start_run(input int cnt);
    q_idx.delete(); q_data.delete(); q_cyc.delete();
    done_cnt = 0;
    @(negedge Clk);
    start = 1'b1; count = (AW+1)'(cnt); start_cyc = cyc;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 500) begin
      @(negedge Clk); #1;
      k++;
    end
    check({tag, " done_seen"}, 32'(done_cnt > 0), 1);
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    int k;
    #12;
    check("reset outputs", {a, b, m, cin, busy, done, res_valid, res_data, res_idx, of_count}, 0);
    @(negedge Clk); nReset = 1'b1;

    // Test 2: three-op program
    prog_write(0, 4'b1111, 4'b0001, 4'b0000, 1'b0);
    prog_write(1, 4'b1010, 4'b0101, 4'b0001, 1'b0);
    prog_write(2, 4'b0111, 4'b1100, 4'b0011, 1'b0);
    start_run(3);
    wait_done("t2");
    check("t2 nres", q_idx.size(), 3);
    if (q_idx.size() == 3) begin
      check("t2 idx0", q_idx[0], 0);
      check("t2 idx1", q_idx[1], 1);
      check("t2 idx2", q_idx[2], 2);
      check("t2 data0", q_data[0], 5'b10000);
      check("t2 data1", q_data[1], 5'b00101);
      check("t2 data2", q_data[2], 5'b00100);
      check("t2 first latency", q_cyc[0] - start_cyc, 4);
      check("t2 period01", q_cyc[1] - q_cyc[0], 3);
      check("t2 period12", q_cyc[2] - q_cyc[1], 3);
      check("t2 done after last", done_cyc - q_cyc[2], 1);
    end
    check("t2 of_count", of_count, 1);
    check("t2 done count", done_cnt, 1);
    check("t2 busy after", busy, 0);

    // Test 3: empty run
    start_run(0);
    wait_done("t3");
    check("t3 done latency", done_cyc - start_cyc, 2);
    check("t3 no results", q_idx.size(), 0);
    check("t3 operands kept", {a, b, m, cin}, {4'b0111, 4'b1100, 4'b0011, 1'b0});
    check("t3 of_count cleared", of_count, 0);

    // Test 4: start and program write during a run are dropped
    start_run(3);
    prog_we = 1'b1; prog_addr = '0; prog_data = {4'b0001, 4'b0001, 4'b0000, 1'b0};
    start = 1'b1; count = 5'd1;
    @(negedge Clk);
    prog_we = 1'b0; start = 1'b0;
    wait_done("t4");
    check("t4 nres", q_idx.size(), 3);
    check("t4 done count", done_cnt, 1);
    if (q_data.size() == 3) check("t4 data2", q_data[2], 5'b00100);
    start_run(1);
    wait_done("t4b");
    check("t4b nres", q_idx.size(), 1);
    if (q_data.size() == 1) check("t4b ram0 old", q_data[0], 5'b10000);
    check("t4b a old", a, 4'b1111);

    // Test 5: count beyond depth clamps to 16 ops
    for (int i = 0; i < 16; i++) prog_write(i, 4'(i), 4'b0001, 4'b0000, 1'b0);
    start_run(20);
    wait_done("t5");
    check("t5 nres", q_idx.size(), 16);
    if (q_idx.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("t5 idx%0d", i), q_idx[i], i);
        check($sformatf("t5 data%0d", i), q_data[i], i + 1);
      end
    end
    check("t5 of_count", of_count, 1);
    check("t5 done count", done_cnt, 1);

    // Test 6 (and mid-cycle async reset): abort during WAIT of op 1
    start_run(3);
    k = 0;
    while (q_idx.size() == 0 && k < 100) begin
      @(negedge Clk); #1;
      k++;
    end
    check("t6 op0 seen", q_idx.size(), 1);
    @(negedge Clk);
    #2 nReset = 1'b0;
    #1 check("t6 async reset outputs",
             {a, b, m, cin, busy, done, res_valid, res_data, res_idx, of_count}, 0);
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    repeat (5) @(negedge Clk);
    check("t6 no res after abort", q_idx.size(), 1);
    check("t6 no done after abort", done_cnt, 0);
    start_run(2);
    wait_done("t6b");
    check("t6b nres", q_idx.size(), 2);
    if (q_idx.size() == 2) begin
      check("t6b idx0", q_idx[0], 0);
      check("t6b idx1", q_idx[1], 1);
      check("t6b data1", q_data[1], 2);
    end
    check("t6b done count", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
